// File: rtl/gat_load_scheduler.sv
// Load/run sequencer for gat_top: demultiplexes one host stream into the weight,
// node-info and h_data BRAM write ports, then drives one or two GAT layers.
module gat_load_scheduler #(
  parameter int HOST_W           = 64,
  parameter int H_DATA_WIDTH     = 32,
  parameter int H_DATA_ADDR_W    = 12,
  parameter int NODE_INFO_WIDTH  = 24,
  parameter int NODE_INFO_ADDR_W = 8,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_ADDR_W    = 10,
  parameter int CNT_W            = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        two_layer_i,
  input  logic [CNT_W-1:0]            cfg_wgt_cnt0_i,
  input  logic [CNT_W-1:0]            cfg_wgt_cnt1_i,
  input  logic [CNT_W-1:0]            cfg_info_cnt_i,
  input  logic [CNT_W-1:0]            cfg_hdata_cnt_i,
  input  logic [HOST_W-1:0]           s_data_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  output logic [DATA_WIDTH-1:0]       wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W-1:0]    wgt_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W-1:0] h_node_info_bram_addra,
  output logic [H_DATA_WIDTH-1:0]     h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W-1:0]    h_data_bram_addra,
  output logic                        wgt_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        h_data_bram_load_done,
  output logic                        gat_layer,
  input  logic                        gat_ready,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_WGT   = 3'd1,
    S_LD_INFO  = 3'd2,
    S_LD_HDATA = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state;
  state_t           load_next;
  logic             two_layer_q;
  logic [CNT_W-1:0] wgt_cnt0_q;
  logic [CNT_W-1:0] wgt_cnt1_q;
  logic [CNT_W-1:0] info_cnt_q;
  logic [CNT_W-1:0] hdata_cnt_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cur_cnt;
  logic             gat_ready_q;
  logic             in_load;
  logic             skip;
  logic             accept;
  logic             last_beat;
  logic             ready_edge;
  logic             unused_host_bits;

  // Only the low bits of each host beat are meaningful for any one port.
  assign unused_host_bits = ^s_data_i;

  assign dbg_state = state;
  assign busy_o    = (state != S_IDLE);

  always_comb begin
    cur_cnt   = '0;
    load_next = S_IDLE;
    case (state)
      S_LD_WGT: begin
        cur_cnt   = gat_layer ? wgt_cnt1_q : wgt_cnt0_q;
        load_next = gat_layer ? S_RUN : S_LD_INFO;
      end
      S_LD_INFO: begin
        cur_cnt   = info_cnt_q;
        load_next = S_LD_HDATA;
      end
      S_LD_HDATA: begin
        cur_cnt   = hdata_cnt_q;
        load_next = S_RUN;
      end
      default: begin
        cur_cnt   = '0;
        load_next = S_IDLE;
      end
    endcase
  end

  // Host handshake: a beat transfers on any rising clk where s_valid_i and
  // s_ready_o are both high. s_ready_o is a pure decode of registered state
  // (load state with a non-zero count), so a zero-count state never swallows
  // a beat and the last beat of a state is always consumed by that state.
  assign in_load    = (state == S_LD_WGT) || (state == S_LD_INFO) || (state == S_LD_HDATA);
  assign s_ready_o  = in_load && (cur_cnt != '0);
  assign skip       = in_load && (cur_cnt == '0);
  assign accept     = s_valid_i && s_ready_o;
  assign last_beat  = (beat_cnt == cur_cnt - CNT_W'(1));
  assign ready_edge = gat_ready && !gat_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                      <= S_IDLE;
      two_layer_q                <= 1'b0;
      wgt_cnt0_q                 <= '0;
      wgt_cnt1_q                 <= '0;
      info_cnt_q                 <= '0;
      hdata_cnt_q                <= '0;
      beat_cnt                   <= '0;
      gat_ready_q                <= 1'b0;
      wgt_bram_din               <= '0;
      wgt_bram_ena               <= 1'b0;
      wgt_bram_wea               <= 1'b0;
      wgt_bram_addra             <= '0;
      h_node_info_bram_din       <= '0;
      h_node_info_bram_ena       <= 1'b0;
      h_node_info_bram_wea       <= 1'b0;
      h_node_info_bram_addra     <= '0;
      h_data_bram_din            <= '0;
      h_data_bram_ena            <= 1'b0;
      h_data_bram_wea            <= 1'b0;
      h_data_bram_addra          <= '0;
      wgt_bram_load_done         <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      h_data_bram_load_done      <= 1'b0;
      gat_layer                  <= 1'b0;
      done_o                     <= 1'b0;
    end else begin
      // gat_ready is tracked in every state so a level left high from the
      // previous layer (or from before start) never looks like a new edge.
      gat_ready_q          <= gat_ready;
      wgt_bram_ena         <= 1'b0;
      wgt_bram_wea         <= 1'b0;
      h_node_info_bram_ena <= 1'b0;
      h_node_info_bram_wea <= 1'b0;
      h_data_bram_ena      <= 1'b0;
      h_data_bram_wea      <= 1'b0;
      done_o               <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            two_layer_q                <= two_layer_i;
            wgt_cnt0_q                 <= cfg_wgt_cnt0_i;
            wgt_cnt1_q                 <= cfg_wgt_cnt1_i;
            info_cnt_q                 <= cfg_info_cnt_i;
            hdata_cnt_q                <= cfg_hdata_cnt_i;
            wgt_bram_load_done         <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            h_data_bram_load_done      <= 1'b0;
            gat_layer                  <= 1'b0;
            beat_cnt                   <= '0;
            state                      <= S_LD_WGT;
          end
        end

        S_LD_WGT, S_LD_INFO, S_LD_HDATA: begin
          if (accept) begin
            case (state)
              S_LD_WGT: begin
                wgt_bram_ena   <= 1'b1;
                wgt_bram_wea   <= 1'b1;
                wgt_bram_din   <= s_data_i[DATA_WIDTH-1:0];
                wgt_bram_addra <= beat_cnt[WEIGHT_ADDR_W-1:0];
              end
              S_LD_INFO: begin
                h_node_info_bram_ena   <= 1'b1;
                h_node_info_bram_wea   <= 1'b1;
                h_node_info_bram_din   <= s_data_i[NODE_INFO_WIDTH-1:0];
                h_node_info_bram_addra <= beat_cnt[NODE_INFO_ADDR_W-1:0];
              end
              S_LD_HDATA: begin
                h_data_bram_ena   <= 1'b1;
                h_data_bram_wea   <= 1'b1;
                h_data_bram_din   <= s_data_i[H_DATA_WIDTH-1:0];
                h_data_bram_addra <= beat_cnt[H_DATA_ADDR_W-1:0];
              end
              default: ;
            endcase
          end

          if (skip || (accept && last_beat)) begin
            case (state)
              S_LD_WGT:   wgt_bram_load_done         <= 1'b1;
              S_LD_INFO:  h_node_info_bram_load_done <= 1'b1;
              S_LD_HDATA: h_data_bram_load_done      <= 1'b1;
              default: ;
            endcase
            beat_cnt <= '0;
            state    <= load_next;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (ready_edge) begin
            if (!gat_layer && two_layer_q) begin
              // Layer 1 reuses node info and h_data; only weights reload.
              gat_layer          <= 1'b1;
              wgt_bram_load_done <= 1'b0;
              beat_cnt           <= '0;
              state              <= S_LD_WGT;
            end else begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gat_load_scheduler.sv
// Directed bench for gat_load_scheduler: host stream driver, BRAM write
// scoreboard with expected queues, and immediate-assertion checks.
module tb_gat_load_scheduler;

  localparam int HOST_W = 64;
  localparam int DW     = 16;
  localparam int WAW    = 10;
  localparam int NIW    = 24;
  localparam int NIAW   = 8;
  localparam int HDW    = 32;
  localparam int HDAW   = 12;
  localparam int CNT_W  = 20;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LD_WGT   = 3'd1;
  localparam logic [2:0] ST_LD_INFO  = 3'd2;
  localparam logic [2:0] ST_LD_HDATA = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              two_layer_i;
  logic [CNT_W-1:0]  cfg_wgt_cnt0_i;
  logic [CNT_W-1:0]  cfg_wgt_cnt1_i;
  logic [CNT_W-1:0]  cfg_info_cnt_i;
  logic [CNT_W-1:0]  cfg_hdata_cnt_i;
  logic [HOST_W-1:0] s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DW-1:0]     wgt_bram_din;
  logic              wgt_bram_ena;
  logic              wgt_bram_wea;
  logic [WAW-1:0]    wgt_bram_addra;
  logic [NIW-1:0]    h_node_info_bram_din;
  logic              h_node_info_bram_ena;
  logic              h_node_info_bram_wea;
  logic [NIAW-1:0]   h_node_info_bram_addra;
  logic [HDW-1:0]    h_data_bram_din;
  logic              h_data_bram_ena;
  logic              h_data_bram_wea;
  logic [HDAW-1:0]   h_data_bram_addra;
  logic              wgt_bram_load_done;
  logic              h_node_info_bram_load_done;
  logic              h_data_bram_load_done;
  logic              gat_layer;
  logic              gat_ready;
  logic              busy_o;
  logic              done_o;
  logic [2:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int n_wgt_wr, n_info_wr, n_hdata_wr;
  int nx;
  logic [63:0] exp_wgt_q[$];
  logic [63:0] exp_info_q[$];
  logic [63:0] exp_hdata_q[$];
  logic [63:0] e_w, e_i, e_h;

  gat_load_scheduler #(
    .HOST_W(HOST_W), .H_DATA_WIDTH(HDW), .H_DATA_ADDR_W(HDAW),
    .NODE_INFO_WIDTH(NIW), .NODE_INFO_ADDR_W(NIAW),
    .DATA_WIDTH(DW), .WEIGHT_ADDR_W(WAW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .two_layer_i(two_layer_i),
    .cfg_wgt_cnt0_i(cfg_wgt_cnt0_i), .cfg_wgt_cnt1_i(cfg_wgt_cnt1_i),
    .cfg_info_cnt_i(cfg_info_cnt_i), .cfg_hdata_cnt_i(cfg_hdata_cnt_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
    .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
    .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
    .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
    .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
    .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
    .wgt_bram_load_done(wgt_bram_load_done),
    .h_node_info_bram_load_done(h_node_info_bram_load_done),
    .h_data_bram_load_done(h_data_bram_load_done),
    .gat_layer(gat_layer), .gat_ready(gat_ready),
    .busy_o(busy_o), .done_o(done_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input int job, input int idx);
    logic [15:0] j, i;
    j = 16'(job);
    i = 16'(idx);
    return {16'hD000 | j, i, i * 16'h0301 + j, 16'hBEEF ^ (i * 16'd7 + j)};
  endfunction

  function automatic logic [63:0] pack(input int addr, input logic [63:0] data, input int w);
    return (64'(addr) << 48) | (data & ((64'd1 << w) - 64'd1));
  endfunction

  task automatic push_exp(input int port, input int job, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      case (port)
        0:       exp_wgt_q.push_back(pack(k, beat_val(job, first + k), DW));
        1:       exp_info_q.push_back(pack(k, beat_val(job, first + k), NIW));
        default: exp_hdata_q.push_back(pack(k, beat_val(job, first + k), HDW));
      endcase
    end
  endtask

  // ---------------- scoreboard: every BRAM write must match the queue head ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (wgt_bram_ena) begin
        n_wgt_wr++;
        chk("wgt_wea", 64'(wgt_bram_wea), 64'd1);
        if (exp_wgt_q.size() > 0) e_w = exp_wgt_q.pop_front();
        else e_w = '1;
        chk("wgt_write", (64'(wgt_bram_addra) << 48) | 64'(wgt_bram_din), e_w);
      end
      if (h_node_info_bram_ena) begin
        n_info_wr++;
        chk("info_wea", 64'(h_node_info_bram_wea), 64'd1);
        if (exp_info_q.size() > 0) e_i = exp_info_q.pop_front();
        else e_i = '1;
        chk("info_write", (64'(h_node_info_bram_addra) << 48) | 64'(h_node_info_bram_din), e_i);
      end
      if (h_data_bram_ena) begin
        n_hdata_wr++;
        chk("hdata_wea", 64'(h_data_bram_wea), 64'd1);
        if (exp_hdata_q.size() > 0) e_h = exp_hdata_q.pop_front();
        else e_h = '1;
        chk("hdata_write", (64'(h_data_bram_addra) << 48) | 64'(h_data_bram_din), e_h);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input bit two, input int c0, input int c1, input int ci, input int ch);
    n_wgt_wr = 0; n_info_wr = 0; n_hdata_wr = 0;
    @(negedge clk);
    two_layer_i     = two;
    cfg_wgt_cnt0_i  = CNT_W'(c0);
    cfg_wgt_cnt1_i  = CNT_W'(c1);
    cfg_info_cnt_i  = CNT_W'(ci);
    cfg_hdata_cnt_i = CNT_W'(ch);
    start_i         = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    // Scramble cfg after start; the DUT must run on the latched values.
    two_layer_i     = !two;
    cfg_wgt_cnt0_i  = CNT_W'($urandom_range(20, 60));
    cfg_wgt_cnt1_i  = CNT_W'($urandom_range(20, 60));
    cfg_info_cnt_i  = CNT_W'($urandom_range(20, 60));
    cfg_hdata_cnt_i = CNT_W'($urandom_range(20, 60));
    #1;
    chk("start_busy", 64'(busy_o), 64'd1);
    chk("start_state", 64'(dbg_state), 64'(ST_LD_WGT));
    chk("start_flags", 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'd0);
    chk("start_layer", 64'(gat_layer), 64'd0);
  endtask

  task automatic stream(input int job, input int first, input int n, input bit gaps, output int next);
    int i;
    int budget;
    i = first;
    budget = 0;
    while (i < first + n && budget < 2000) begin
      @(negedge clk);
      s_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = beat_val(job, i);
      #1;
      if (s_valid_i && s_ready_o) i++;
      budget++;
    end
    chk("stream_beats_accepted", 64'(i - first), 64'(n));
    @(negedge clk);
    s_valid_i = 1'b0;
    s_data_i  = '0;
    #1;
    next = i;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wgt_port"}, {wgt_bram_ena, wgt_bram_wea, 6'd0, 6'(wgt_bram_addra), 10'd0, 8'd0, 16'd0, wgt_bram_din}, 64'd0);
    chk({tag, "_info_port"}, {h_node_info_bram_ena, h_node_info_bram_wea, 6'd0, h_node_info_bram_addra, 24'd0, h_node_info_bram_din}, 64'd0);
    chk({tag, "_hdata_port"}, {h_data_bram_ena, h_data_bram_wea, 2'd0, h_data_bram_addra, 16'd0, h_data_bram_din}, 64'd0);
    chk({tag, "_flags"}, 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'd0);
    chk({tag, "_layer"}, 64'(gat_layer), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_ready"}, 64'(s_ready_o), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_wgt_q_empty"}, 64'(exp_wgt_q.size()), 64'd0);
    chk({tag, "_info_q_empty"}, 64'(exp_info_q.size()), 64'd0);
    chk({tag, "_hdata_q_empty"}, 64'(exp_hdata_q.size()), 64'd0);
  endtask

  // One gat_ready pulse in RUN ends the final layer.
  task automatic finish_job(input string tag, input logic exp_layer);
    @(negedge clk);
    gat_ready = 1'b1;
    @(negedge clk);
    gat_ready = 1'b0;
    #1;
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd1);
    chk({tag, "_done_state"}, 64'(dbg_state), 64'(ST_DONE));
    chk({tag, "_done_layer"}, 64'(gat_layer), 64'(exp_layer));
    @(negedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_flags_hold"}, 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'd7);
    chk({tag, "_layer_hold"}, 64'(gat_layer), 64'(exp_layer));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start_i = 1'b0; two_layer_i = 1'b0;
    cfg_wgt_cnt0_i = '0; cfg_wgt_cnt1_i = '0; cfg_info_cnt_i = '0; cfg_hdata_cnt_i = '0;
    s_data_i = '0; s_valid_i = 1'b0; gat_ready = 1'b0;
    n_wgt_wr = 0; n_info_wr = 0; n_hdata_wr = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;

    // Job 1: single layer, phased loads so flag order is visible.
    push_exp(0, 1, 0, 4);
    push_exp(1, 1, 4, 3);
    push_exp(2, 1, 7, 5);
    do_start(1'b0, 4, 9, 3, 5);
    stream(1, 0, 4, 1'b0, nx);
    chk("j1_after_wgt", 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'b100);
    chk("j1_state_info", 64'(dbg_state), 64'(ST_LD_INFO));
    stream(1, nx, 3, 1'b0, nx);
    chk("j1_after_info", 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'b110);
    chk("j1_state_hdata", 64'(dbg_state), 64'(ST_LD_HDATA));
    stream(1, nx, 5, 1'b0, nx);
    chk("j1_after_hdata", 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'b111);
    chk("j1_state_run", 64'(dbg_state), 64'(ST_RUN));
    chk("j1_ready_low_in_run", 64'(s_ready_o), 64'd0);
    chk("j1_write_counts", {16'(n_wgt_wr), 16'(n_info_wr), 16'(n_hdata_wr), 16'd0}, {16'd4, 16'd3, 16'd5, 16'd0});
    chk_drained("j1");
    repeat (3) @(negedge clk);
    #1;
    chk("j1_run_waits", 64'({done_o, dbg_state}), 64'({1'b0, ST_RUN}));
    finish_job("j1", 1'b0);

    // Job 2: two layers, one contiguous always-valid stream for layer 0.
    push_exp(0, 2, 0, 4);
    push_exp(1, 2, 4, 3);
    push_exp(2, 2, 7, 5);
    do_start(1'b1, 4, 2, 3, 5);
    stream(2, 0, 12, 1'b0, nx);
    chk("j2_l0_flags", 64'({wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}), 64'b111);
    chk("j2_l0_state", 64'(dbg_state), 64'(ST_RUN));
    chk_drained("j2_l0");
    push_exp(0, 2, 12, 2);
    @(negedge clk);
    gat_ready = 1'b1;
    @(negedge clk);
    gat_ready = 1'b0;
    #1;
    chk("j2_l1_wgt_cleared", 64'(wgt_bram_load_done), 64'd0);
    chk("j2_l1_reuse_flags", 64'({h_node_info_bram_load_done, h_data_bram_load_done}), 64'b11);
    chk("j2_l1_layer", 64'(gat_layer), 64'd1);
    chk("j2_l1_state", 64'(dbg_state), 64'(ST_LD_WGT));
    chk("j2_l1_no_done", 64'(done_o), 64'd0);
    stream(2, nx, 2, 1'b0, nx);
    chk("j2_l1_wgt_done", 64'(wgt_bram_load_done), 64'd1);
    chk("j2_l1_state_run", 64'(dbg_state), 64'(ST_RUN));
    chk("j2_write_counts", {16'(n_wgt_wr), 16'(n_info_wr), 16'(n_hdata_wr), 16'd0}, {16'd6, 16'd3, 16'd5, 16'd0});
    chk_drained("j2_l1");
    finish_job("j2", 1'b1);

    // Job 3: same counts with random valid gaps.
    push_exp(0, 3, 0, 4);
    push_exp(1, 3, 4, 3);
    push_exp(2, 3, 7, 5);
    do_start(1'b0, 4, 0, 3, 5);
    stream(3, 0, 12, 1'b1, nx);
    chk("j3_state_run", 64'(dbg_state), 64'(ST_RUN));
    chk("j3_write_counts", {16'(n_wgt_wr), 16'(n_info_wr), 16'(n_hdata_wr), 16'd0}, {16'd4, 16'd3, 16'd5, 16'd0});
    chk_drained("j3");
    finish_job("j3", 1'b0);

    // Job 4: zero node-info count skips LD_INFO without writes or lost beats.
    push_exp(0, 4, 0, 2);
    push_exp(2, 4, 2, 3);
    do_start(1'b0, 2, 0, 0, 3);
    stream(4, 0, 5, 1'b0, nx);
    chk("j4_info_flag", 64'(h_node_info_bram_load_done), 64'd1);
    chk("j4_info_writes", 64'(n_info_wr), 64'd0);
    chk("j4_state_run", 64'(dbg_state), 64'(ST_RUN));
    chk_drained("j4");
    finish_job("j4", 1'b0);

    // Job 5: gat_ready already high before start must not end the layer.
    @(negedge clk);
    gat_ready = 1'b1;
    push_exp(0, 5, 0, 1);
    push_exp(1, 5, 1, 1);
    push_exp(2, 5, 2, 1);
    do_start(1'b0, 1, 0, 1, 1);
    stream(5, 0, 3, 1'b0, nx);
    repeat (4) @(negedge clk);
    #1;
    chk("j5_stale_level_ignored", 64'({done_o, dbg_state}), 64'({1'b0, ST_RUN}));
    chk_drained("j5");
    @(negedge clk);
    gat_ready = 1'b0;
    finish_job("j5", 1'b0);

    // Job 6: start ignored while busy, then reset at hdata beat 2.
    push_exp(0, 6, 0, 4);
    push_exp(1, 6, 4, 3);
    push_exp(2, 6, 7, 2);
    do_start(1'b0, 4, 0, 3, 5);
    stream(6, 0, 9, 1'b0, nx);
    chk("j6_state_hdata", 64'(dbg_state), 64'(ST_LD_HDATA));
    @(negedge clk);
    cfg_wgt_cnt0_i = CNT_W'(1);
    cfg_hdata_cnt_i = CNT_W'(1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("j6_busy_start_ignored", 64'({dbg_state, h_data_bram_load_done, wgt_bram_load_done}), 64'({ST_LD_HDATA, 1'b0, 1'b1}));
    chk_drained("j6");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("midreset");
    rst_n = 1'b1;
    exp_wgt_q.delete();
    exp_info_q.delete();
    exp_hdata_q.delete();

    // Job 7: clean restart after the abort.
    push_exp(0, 7, 0, 4);
    push_exp(1, 7, 4, 3);
    push_exp(2, 7, 7, 5);
    do_start(1'b0, 4, 0, 3, 5);
    stream(7, 0, 12, 1'b0, nx);
    chk("j7_state_run", 64'(dbg_state), 64'(ST_RUN));
    chk("j7_write_counts", {16'(n_wgt_wr), 16'(n_info_wr), 16'(n_hdata_wr), 16'd0}, {16'd4, 16'd3, 16'd5, 16'd0});
    chk_drained("j7");
    finish_job("j7", 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gat_load_scheduler.md
Name: gat_load_scheduler

Overview:
- Sequences a complete GAT inference around gat_top.
- Accepts a single host valid/ready stream and demultiplexes it, in fixed order, into the weight, node-info and h_data BRAM write ports, then raises the matching load_done flags.
- Drives gat_layer, waits for layer completion on gat_ready, and optionally re-runs for layer 1 with only a weight reload.
- Sits between the host/DMA front end and gat_top.

Parameters:
- HOST_W, 64: host stream data width; must be >= max(H_DATA_WIDTH, NODE_INFO_WIDTH, DATA_WIDTH).
- H_DATA_WIDTH, H_DATA_ADDR_W, NODE_INFO_WIDTH, NODE_INFO_ADDR_W, DATA_WIDTH, WEIGHT_ADDR_W: gat_pkg values; BRAM port widths.
- CNT_W, 20: width of beat-count configuration inputs.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  one-cycle start pulse; ignored unless state is IDLE
- two_layer_i  in  1  sampled at start; 1 = run layer 0 then layer 1
- cfg_wgt_cnt0_i  in  CNT_W  layer-0 weight beats, sampled at start
- cfg_wgt_cnt1_i  in  CNT_W  layer-1 weight beats, sampled at start
- cfg_info_cnt_i  in  CNT_W  node-info beats, sampled at start
- cfg_hdata_cnt_i  in  CNT_W  h_data beats, sampled at start
- s_data_i  in  HOST_W  host beat; low bits used
- s_valid_i  in  1  host beat valid
- s_ready_o  out  1  scheduler accepts beat
- wgt_bram_din/ena/wea/addra  out  DATA_WIDTH/1/1/WEIGHT_ADDR_W  weight BRAM write port
- h_node_info_bram_din/ena/wea/addra  out  NODE_INFO_WIDTH/1/1/NODE_INFO_ADDR_W  node-info write port
- h_data_bram_din/ena/wea/addra  out  H_DATA_WIDTH/1/1/H_DATA_ADDR_W  h_data write port
- wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done  out  1  load-complete flags
- gat_layer  out  1  active layer index
- gat_ready  in  1  layer-complete indication from gat_top
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the whole job finishes

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
  - Reset mid-operation aborts immediately.
  - Partially written BRAM contents are don't-care.
- States: IDLE, LD_WGT, LD_INFO, LD_HDATA, RUN, DONE.
- IDLE:
  - start_i latches all cfg inputs, clears all load_done flags and gat_layer, and moves to LD_WGT the next cycle.
  - start_i in any other state is ignored.
- Load states:
  - s_ready_o = 1 combinationally while in a load state; otherwise 0.
  - An accepted beat is s_valid_i & s_ready_o.
  - On an accepted beat the active port drives ena = wea = 1, din = s_data_i[width-1:0] and addra = beat counter, all registered, i.e. 1-cycle latency. Other ports hold ena = wea = 0.
  - The counter starts at 0 on state entry.
  - On the beat where counter == cnt-1, that port's load_done is set the following cycle and the state advances.
  - A count of 0 skips the state and sets its load_done with no writes.
- Order:
  - Layer 0: LD_WGT(cnt0) -> LD_INFO -> LD_HDATA -> RUN.
  - Layer 1: LD_WGT(cnt1) -> RUN. Node info and h_data are reused; their flags stay 1.
  - On entering layer-1 LD_WGT, wgt_bram_load_done is cleared and gat_layer = 1.
- RUN:
  - Completion is a rising edge of gat_ready (registered previous value), so a stale high level from the previous layer is not counted.
  - Edge with gat_layer = 0 and two_layer latched: go to LD_WGT for layer 1.
  - Otherwise go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. load_done flags and gat_layer hold until the next start.
- Simultaneous s_valid_i and state transition: the last beat of a state is consumed in that state, and the next state begins accepting the following cycle. No beat is dropped or duplicated.
- The host may stall (s_valid_i = 0) indefinitely in any load state; the counter holds.

Test Plan:
- Single layer, counts wgt = 4, info = 3, hdata = 5, host always valid → writes wgt addr 0..3, info 0..2, hdata 0..4 with data matching beats, in order, 12 beats total. Flags set in order. Pulse gat_ready → done_o one cycle later, gat_layer = 0.
- two_layer = 1, cnt1 = 2 → after the first gat_ready edge, wgt_bram_load_done drops and gat_layer = 1. Two weight writes at addr 0..1; no info/hdata writes. Second gat_ready edge → done_o.
- Random s_valid_i gaps (50%) with the same counts → identical write sequence; addresses contiguous, no duplicates.
- cfg_info_cnt = 0 → LD_INFO skipped, h_node_info_bram_load_done = 1 with zero ena pulses.
- gat_ready held high from before start → no early completion; only a fresh 0→1 edge in RUN ends the layer.
- rst_n low during LD_HDATA at beat 2, then restart → all outputs 0 after reset; second run completes normally; start_i pulsed while busy has no effect.
